conv_pool_sink: RTL
===================

Name: conv_pool_sink

Overview:
- Receiving end of the layer-2 convolver output stream.
- Captures each strobed 32-bit signed conv result and applies ReLU.
- Max-pools adjacent pairs (window 2, stride 2) within each per-channel segment.
- Right-shifts and saturates each pooled value to a 17-bit unsigned activation, then buffers it in a FIFO that the next layer drains with a read handshake.
- Tracks the segment index, running maximum, sticky overflow and completion.

Parameters:
- OUTLEN_PER, 30: conv outputs per channel segment.
- OUTLEN_ALL, 1260: total conv outputs per image; a multiple of OUTLEN_PER.
- SHIFT, 4: requantisation right shift applied after ReLU.
- OUT_W, 17: output activation width.
- FIFO_DEPTH, 16: FIFO entries; a power of 2 and at least 2.

Ports:
- clk  in  1  rising-edge clock.
- global_rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous restart for the next image; clears counters, FIFO and flags.
- in_valid  in  1  conv result strobe.
- in_data  in  32  signed conv result (bias already added).
- rd_en  in  1  FIFO read request.
- rd_data  out  OUT_W  activation read from the FIFO.
- rd_valid  out  1  rd_data valid; one-cycle pulse.
- empty  out  1  FIFO empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- seg_idx  out  11  index of the current segment.
- max_out  out  32  largest post-ReLU input seen in this image.
- overflow  out  1  sticky: a pooled value was dropped.
- done  out  1  all inputs received and the FIFO is drained.

Behaviour:
- Reset (async, global_rst_n=0) and clr (sync) give identical state:
  - FSM in IDLE.
  - in_cnt=0, seg_idx=0, pos-in-segment=0, pair register empty.
  - FIFO empty: empty=1, fifo_count=0.
  - rd_data=0, rd_valid=0, max_out=0, overflow=0, done=0.
- Capture: in_data is sampled on the rising edge where in_valid=1. No backpressure exists toward the convolver.
- ReLU: r = (in_data<0) ? 0 : in_data.
- max_out updates to r on any capture where r > max_out.
- Pooling:
  - On an even position in the segment, hold r in the pair register.
  - On an odd position, p = max(held, r).
  - A pair never spans a segment boundary.
  - If OUTLEN_PER is odd, the last element of a segment is emitted alone (p = r).
- Requantisation: q = p >> SHIFT (logical), saturated to 2^OUT_W-1.
- Latency: q is written to the FIFO on the edge after the capture that completed the pair; fifo_count reflects it that cycle.
- Counters:
  - in_cnt increments on each capture.
  - When the position reaches OUTLEN_PER-1 it wraps to 0 and seg_idx increments.
- FSM states and transitions:
  - IDLE -> COLLECT on the first capture.
  - COLLECT -> DRAIN after capture number OUTLEN_ALL, once that pooled value has been written.
  - DRAIN -> DONE when empty=1.
  - DONE holds until clr; done=1 only in DONE.
  - In DRAIN and DONE, in_valid is ignored.
- FIFO write when full with rd_en=0: the value is dropped and overflow is set (sticky until reset or clr).
- FIFO write when full with rd_en=1 in the same cycle: the write is accepted and the count is unchanged.
- Read:
  - rd_en while not empty pops the head; rd_data is registered and rd_valid pulses on the next cycle.
  - rd_en while empty is ignored (no rd_valid, no underflow).
- Simultaneous read and write while not full: occupancy is unchanged.
- clr asserted together with in_valid: clr wins and the input is discarded.
- Reset mid-image: all state is lost; the next image starts from IDLE.

Optional Feature:
- Macro CONV_SINK_POOL_EN.
- Defined: pooling exactly as described above; OUTLEN_ALL/2 values are written per image (ceil per segment if OUTLEN_PER is odd).
- Undefined: pooling is bypassed and each post-ReLU, requantised input is written directly, giving OUTLEN_ALL values per image with the same latency.
- ReLU, max_out, overflow and the FSM are unchanged in both builds.

Decomposition:
- Shared package `cnn_layer_pkg`:
  - Activation width constant (17) and conv result width (32).
  - Default OUTLEN_PER and OUTLEN_ALL.
  - FSM state typedef (IDLE, COLLECT, DRAIN, DONE).
  - Saturating-shift function.
- One sub-module: `sync_fifo`, with parameters for width and depth.
- ReLU, pooling and the FSM stay in the top module.

Test Plan:
- Segment start: inputs -5, 40, 100, 36 (SHIFT=4) -> FIFO receives 2, 6; max_out=100.
- Segment boundary: OUTLEN_PER=3, inputs 16, 32, 64, 48 -> values 2, 4 (64 emitted alone), then 48 is held pending; seg_idx becomes 1 after the 3rd capture.
- Saturation: input 0x7FFFFFFF with its pair 0 -> q = 131071 written.
- Overflow: FIFO_DEPTH=2, three pooled writes with no reads -> fifo_count=2, overflow=1. Then one write with rd_en=1 while full -> accepted, count remains 2.
- Full image: 1260 random inputs with continuous reads -> 630 rd_valid pulses in order, then done=1. in_valid afterwards is ignored. clr -> all outputs return to reset values.
- Async reset asserted mid-COLLECT with 5 entries in the FIFO -> empty=1, fifo_count=0, seg_idx=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cnn_layer_pkg.sv
// Shared definitions for the layer-2 CNN datapath: widths, default segment
// geometry, the output-sink FSM state type and the requantisation helper.
package cnn_layer_pkg;

    localparam int ACT_W          = 17;
    localparam int CONV_W         = 32;
    localparam int DEF_OUTLEN_PER = 30;
    localparam int DEF_OUTLEN_ALL = 1260;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN,
        DONE
    } sink_state_t;

    // Logical right shift, then clamp to the largest out_w-bit unsigned value.
    function automatic logic [CONV_W-1:0] sat_shift(
        input logic [CONV_W-1:0] v,
        input int unsigned       shift,
        input int unsigned       out_w
    );
        logic [CONV_W-1:0] s;
        logic [CONV_W-1:0] lim;
        s   = v >> shift;
        lim = (out_w >= CONV_W) ? '1 : ((CONV_W'(1) << out_w) - CONV_W'(1));
        return (s > lim) ? lim : s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and a one-cycle read-valid pulse.
// A write into a full FIFO is accepted only when a read pops in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     rd_valid_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             do_wr;
    logic             do_rd;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == FULL_CNT);
    assign do_rd      = rd_en_i && !empty_o;
    assign do_wr      = wr_en_i && (!full_o || rd_en_i);
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign count_o    = count_q;

    // NOTE: the storage array is deliberately left without reset; the pointers
    // and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= do_rd;
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_rd) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/conv_pool_sink.sv
// Layer-2 conv output sink: ReLU, pair max-pool per segment, requantise, FIFO.
// Build macro CONV_SINK_POOL_EN enables pooling; without it every input is written.
module conv_pool_sink
    import cnn_layer_pkg::*;
#(
    parameter int OUTLEN_PER = DEF_OUTLEN_PER,
    parameter int OUTLEN_ALL = DEF_OUTLEN_ALL,
    parameter int SHIFT      = 4,
    parameter int OUT_W      = ACT_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          global_rst_n,
    input  logic                          clr,
    input  logic                          in_valid,
    input  logic [CONV_W-1:0]             in_data,
    input  logic                          rd_en,
    output logic [OUT_W-1:0]              rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [10:0]                   seg_idx,
    output logic [CONV_W-1:0]             max_out,
    output logic                          overflow,
    output logic                          done
);

    localparam int CNT_W = $clog2(OUTLEN_ALL + 1);
    localparam int POS_W = (OUTLEN_PER > 1) ? $clog2(OUTLEN_PER) : 1;

    sink_state_t       state_q;
    logic [CNT_W-1:0]  in_cnt_q;
    logic [POS_W-1:0]  pos_q;
    logic [10:0]       seg_idx_q;
    logic [CONV_W-1:0] max_q;
    logic              last_q;
    logic              overflow_q;
    logic              done_q;
    logic              wr_en_q;
    logic [OUT_W-1:0]  wr_data_q;
`ifdef CONV_SINK_POOL_EN
    logic [CONV_W-1:0] held_q;
`endif

    logic              accepting;
    logic              capture;
    logic              pos_last;
    logic [CONV_W-1:0] relu;
    logic [CONV_W-1:0] pooled;
    logic              wr_en_d;
    logic [OUT_W-1:0]  wr_data_d;
    logic              fifo_empty;
    logic              fifo_full;

    // Inputs are taken until the last one of the image has been captured.
    assign accepting = (state_q == IDLE) || ((state_q == COLLECT) && !last_q);
    assign capture   = in_valid && !clr && accepting;
    assign relu      = in_data[CONV_W-1] ? '0 : in_data;
    assign pos_last  = (pos_q == POS_W'(OUTLEN_PER - 1));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_en_d = 1'b0;
        pooled  = relu;
`ifdef CONV_SINK_POOL_EN
        if (pos_q[0]) begin
            wr_en_d = capture;
            pooled  = (held_q > relu) ? held_q : relu;
        end else begin
            wr_en_d = capture && pos_last;
        end
`else
        wr_en_d = capture;
`endif
        wr_data_d = OUT_W'(sat_shift(pooled, SHIFT, OUT_W));
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            in_cnt_q   <= '0;
            pos_q      <= '0;
            seg_idx_q  <= '0;
            max_q      <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
`ifdef CONV_SINK_POOL_EN
            held_q     <= '0;
`endif
        end else if (clr) begin
            in_cnt_q   <= '0;
            pos_q      <= '0;
            seg_idx_q  <= '0;
            max_q      <= '0;
            last_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
`ifdef CONV_SINK_POOL_EN
            held_q     <= '0;
`endif
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            if (wr_en_q && fifo_full && !rd_en) begin
                overflow_q <= 1'b1;
            end
            if (capture) begin
                in_cnt_q <= in_cnt_q + CNT_W'(1);
                last_q   <= (in_cnt_q == CNT_W'(OUTLEN_ALL - 1));
                if (relu > max_q) begin
                    max_q <= relu;
                end
                if (pos_last) begin
                    pos_q     <= '0;
                    seg_idx_q <= seg_idx_q + 11'd1;
                end else begin
                    pos_q <= pos_q + POS_W'(1);
                end
`ifdef CONV_SINK_POOL_EN
                if (!pos_q[0]) begin
                    held_q <= relu;
                end
`endif
            end
        end
    end

    // COLLECT leaves on the edge that writes the final pooled value.
    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else if (clr) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        state_q <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (last_q) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (global_rst_n),
        .clr_i      (clr),
        .wr_en_i    (wr_en_q),
        .wr_data_i  (wr_data_q),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .count_o    (fifo_count)
    );

    assign empty    = fifo_empty;
    assign seg_idx  = seg_idx_q;
    assign max_out  = max_q;
    assign overflow = overflow_q;
    assign done     = done_q;

endmodule
